// File: rtl/simon_key_expander.sv
// ---------------------------------------------------------------------------
// SimonKeyExpander
// Sequential SIMON key-schedule engine. A master key of M words is expanded
// into T round keys, one new key per clock, and stored in an internal
// round-key RAM. Every generated key is also streamed out with its index.
// The round cipher reads the finished schedule back through a registered
// read port. Word size, key-word count, round count and z-sequence are
// parameters, so one instance covers every SIMON variant.
// ---------------------------------------------------------------------------
module simon_key_expander #(
   parameter int          N  = 32,
   parameter int          M  = 3,
   parameter int          T  = 42,
   parameter logic [61:0] Z  = 62'b10101111011100000011010010011000101000010001111110010110110011,
   parameter int          AW = $clog2(T)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N*M-1:0] key_in,
   output logic           busy,
   output logic           done,
   output logic           keys_valid,
   output logic           rk_valid,
   output logic [AW-1:0]  rk_idx,
   output logic [N-1:0]   rk_data,
   input  logic [AW-1:0]  rd_addr,
   output logic [N-1:0]   rd_data
);

   // Unsupported key-word counts or a schedule shorter than the master key
   // have no meaning for SIMON, so they stop elaboration outright.
   if (M < 2 || M > 4) begin : gBadKeyWords
      $error("simon_key_expander: M must be 2, 3 or 4");
   end
   if (T <= M) begin : gBadRounds
      $error("simon_key_expander: T must be larger than M");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      GEN  = 2'd2,
      DONE = 2'd3
   } stateType;

   // c = 2^N - 4: all ones except the two lowest bits
   localparam logic [N-1:0] ROUND_CONST = {{(N-2){1'b1}}, 2'b00};

   stateType       state;
   stateType       nextState;

   // Sliding window of the last M keys: word 0 is k[i-M], word M-1 is k[i-1]
   logic [N*M-1:0] window;
   // z-sequence register; its MSB is the z bit for the key being generated
   logic [61:0]    zReg;
   // Index of the key generated in the current GEN cycle
   logic [AW-1:0]  keyIdx;
   logic [N-1:0]   schedTmp;
   logic [N-1:0]   newKey;
   logic           lastKey;

   logic [N-1:0]   roundKeyRam [0:T-1];

   // Rotate an N-bit word right by r positions
   function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int r);
      return (x >> r) | (x << (N - r));
   endfunction

   assign lastKey = (keyIdx == AW'(T - 1));
   assign busy    = (state == LOAD) || (state == GEN);

   // State register; reset always returns the engine to IDLE
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: start only counts in IDLE, GEN runs until k[T-1]
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = LOAD;
         LOAD:    nextState = GEN;
         GEN:     if (lastKey) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // One SIMON key-schedule round computed from the current window and z bit
   always_comb begin
      schedTmp = rotr(window[N*(M-1) +: N], 3);
      if (M == 4) begin
         schedTmp = schedTmp ^ window[N +: N];
      end
      schedTmp = schedTmp ^ rotr(schedTmp, 1);
      newKey   = ROUND_CONST ^ {{(N-1){1'b0}}, zReg[61]} ^ window[N-1:0] ^ schedTmp;
   end

   // Datapath: window/z/index bookkeeping plus the registered status and stream outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         window     <= '0;
         zReg       <= Z;
         keyIdx     <= '0;
         done       <= 1'b0;
         keys_valid <= 1'b0;
         rk_valid   <= 1'b0;
         rk_idx     <= '0;
         rk_data    <= '0;
      end else begin
         done     <= 1'b0;
         rk_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  window     <= key_in;
                  zReg       <= Z;
                  keys_valid <= 1'b0;
               end
            end
            LOAD: begin
               keyIdx <= AW'(M);
            end
            GEN: begin
               window   <= {newKey, window[N*M-1:N]};
               zReg     <= {zReg[60:0], zReg[61]};
               keyIdx   <= keyIdx + 1'b1;
               rk_valid <= 1'b1;
               rk_idx   <= keyIdx;
               rk_data  <= newKey;
            end
            DONE: begin
               done       <= 1'b1;
               keys_valid <= 1'b1;
            end
            default: begin
               done <= 1'b0;
            end
         endcase
      end
   end

   // Round-key RAM writes: the whole master key in LOAD, one new key per GEN cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == LOAD) begin
            for (int j = 0; j < M; j++) begin
               roundKeyRam[j] <= window[N*j +: N];
            end
         end else if (state == GEN) begin
            roundKeyRam[keyIdx] <= newKey;
         end
      end
   end

   // Registered read port; addresses past the schedule read as zero
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
      end else if (int'(rd_addr) < T) begin
         rd_data <= roundKeyRam[rd_addr];
      end else begin
         rd_data <= '0;
      end
   end

endmodule

// File: tb/tb_simon_key_expander.sv
// ---------------------------------------------------------------------------
// Self-checking bench for simon_key_expander. Three instances: the default
// SIMON64/96 shape, an M=4 shape long enough to wrap the z register, and an
// M=2 shape with a different z-sequence. Expected keys come from a plain
// array-based key-schedule model inside the bench.
// ---------------------------------------------------------------------------
module tb_simon_key_expander;

   localparam int NA = 32, MA = 3, TA = 42, AWA = 6;
   localparam int NB = 16, MB = 4, TB = 70, AWB = 7;
   localparam int NC = 24, MC = 2, TC = 26, AWC = 5;
   localparam logic [61:0] ZD = 62'b10101111011100000011010010011000101000010001111110010110110011;
   localparam logic [61:0] ZC = 62'b11111010001001010110000111001101111101000100101011000011100110;

   logic clk;
   logic rst;

   logic             startA, busyA, doneA, keysValidA, rkValidA;
   logic [NA*MA-1:0] keyA;
   logic [AWA-1:0]   rkIdxA, rdAddrA;
   logic [NA-1:0]    rkDataA, rdDataA;

   logic             startB, busyB, doneB, keysValidB, rkValidB;
   logic [NB*MB-1:0] keyB;
   logic [AWB-1:0]   rkIdxB, rdAddrB;
   logic [NB-1:0]    rkDataB, rdDataB;

   logic             startC, busyC, doneC, keysValidC, rkValidC;
   logic [NC*MC-1:0] keyC;
   logic [AWC-1:0]   rkIdxC, rdAddrC;
   logic [NC-1:0]    rkDataC, rdDataC;

   int checks;
   int errors;

   logic [63:0] refK [0:127];

   simon_key_expander #(.N(NA), .M(MA), .T(TA), .Z(ZD)) dutA (
      .clk(clk), .rst(rst), .start(startA), .key_in(keyA),
      .busy(busyA), .done(doneA), .keys_valid(keysValidA),
      .rk_valid(rkValidA), .rk_idx(rkIdxA), .rk_data(rkDataA),
      .rd_addr(rdAddrA), .rd_data(rdDataA)
   );

   simon_key_expander #(.N(NB), .M(MB), .T(TB), .Z(ZD)) dutB (
      .clk(clk), .rst(rst), .start(startB), .key_in(keyB),
      .busy(busyB), .done(doneB), .keys_valid(keysValidB),
      .rk_valid(rkValidB), .rk_idx(rkIdxB), .rk_data(rkDataB),
      .rd_addr(rdAddrB), .rd_data(rdDataB)
   );

   simon_key_expander #(.N(NC), .M(MC), .T(TC), .Z(ZC)) dutC (
      .clk(clk), .rst(rst), .start(startC), .key_in(keyC),
      .busy(busyC), .done(doneC), .keys_valid(keysValidC),
      .rk_valid(rkValidC), .rk_idx(rkIdxC), .rk_data(rkDataC),
      .rd_addr(rdAddrC), .rd_data(rdDataC)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something never finishes
   initial begin
      #400000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] rotrRef(input logic [63:0] x, input int r, input int n);
      logic [63:0] mask;
      mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      return ((x >> r) | (x << (n - r))) & mask;
   endfunction

   // Reference key schedule, indexed directly by round number
   task automatic buildRef(input int n, input int m, input int t,
                           input logic [255:0] key, input logic [61:0] z);
      logic [63:0] mask;
      logic [63:0] tmp;
      logic [63:0] zb;
      mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
      for (int j = 0; j < m; j++) begin
         refK[j] = 64'(key >> (n * j)) & mask;
      end
      for (int i = m; i < t; i++) begin
         tmp = rotrRef(refK[i-1], 3, n);
         if (m == 4) tmp = tmp ^ refK[i-3];
         tmp = tmp ^ rotrRef(tmp, 1, n);
         zb  = {63'd0, z[61 - ((i - m) % 62)]};
         refK[i] = (~64'd3 & mask) ^ zb ^ refK[i-m] ^ tmp;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; startA = 1'b1; startB = 1'b0; startC = 1'b0;
      keyA = 96'h13121110_0b0a0908_03020100; keyB = '0; keyC = '0;
      rdAddrA = '0; rdAddrB = '0; rdAddrC = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0; startA = 1'b0;
      checks++;
      if ({busyA, doneA, keysValidA, rkValidA} !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want 0000", {busyA, doneA, keysValidA, rkValidA});
      end
      checks++;
      if (rkIdxA !== '0 || rkDataA !== '0 || rdDataA !== '0) begin
         errors++;
         $display("[TB] FAIL reset_data got idx %0d data %h rd %h want 0 0 0", rkIdxA, rkDataA, rdDataA);
      end
      @(posedge clk); #1;
      checks++;
      if (busyA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_start_ignored got busy %b want 0", busyA);
      end
   endtask

   task automatic test_expand();
      int doneCyc, pulses;
      buildRef(NA, MA, TA, {160'd0, 96'h13121110_0b0a0908_03020100}, ZD);
      @(negedge clk);
      keyA = 96'h13121110_0b0a0908_03020100; startA = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      checks++;
      if (busyA !== 1'b1 || keysValidA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL expand_cycle0 got busy %b kv %b want 1 0", busyA, keysValidA);
      end
      doneCyc = -1; pulses = 0;
      for (int cyc = 1; cyc <= 60 && doneCyc < 0; cyc++) begin
         @(posedge clk); #1;
         if (rkValidA === 1'b1) begin
            pulses++;
            checks++;
            if (rkIdxA !== AWA'(cyc + 1) || rkDataA !== refK[cyc+1][31:0]) begin
               errors++;
               $display("[TB] FAIL expand_stream got idx %0d key %h want idx %0d key %h",
                        rkIdxA, rkDataA, cyc + 1, refK[cyc+1][31:0]);
            end
            if (cyc + 1 == 3) begin
               checks++;
               if (rkDataA !== 32'hffae9dce) begin
                  errors++;
                  $display("[TB] FAIL expand_k3 got %h want ffae9dce", rkDataA);
               end
            end
            if (cyc + 1 == 4) begin
               checks++;
               if (rkDataA !== 32'hc4facc91) begin
                  errors++;
                  $display("[TB] FAIL expand_k4 got %h want c4facc91", rkDataA);
               end
            end
         end
         if (doneA === 1'b1) doneCyc = cyc;
      end
      checks++;
      if (doneCyc != TA - MA + 2) begin
         errors++;
         $display("[TB] FAIL expand_done_cycle got %0d want %0d", doneCyc, TA - MA + 2);
      end
      checks++;
      if (pulses != TA - MA) begin
         errors++;
         $display("[TB] FAIL expand_pulses got %0d want %0d", pulses, TA - MA);
      end
      checks++;
      if (keysValidA !== 1'b1 || busyA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL expand_final got kv %b busy %b want 1 0", keysValidA, busyA);
      end
      @(posedge clk); #1;
      checks++;
      if (doneA !== 1'b0 || keysValidA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL expand_done_pulse got done %b kv %b want 0 1", doneA, keysValidA);
      end
   endtask

   task automatic test_readback();
      int          addrs [8];
      logic [31:0] want  [8];
      addrs = '{0, 1, 2, 3, 4, 41, 42, 63};
      want[0] = 32'h03020100; want[1] = 32'h0b0a0908; want[2] = 32'h13121110;
      want[3] = 32'hffae9dce; want[4] = 32'hc4facc91; want[5] = refK[41][31:0];
      want[6] = 32'h0;        want[7] = 32'h0;
      for (int k = 0; k < 8; k++) begin
         rdAddrA = AWA'(addrs[k]);
         @(posedge clk); #1;
         checks++;
         if (rdDataA !== want[k]) begin
            errors++;
            $display("[TB] FAIL readback addr %0d got %h want %h", addrs[k], rdDataA, want[k]);
         end
      end
      rdAddrA = '0;
   endtask

   task automatic test_m4_wrap();
      int doneCyc, pulses;
      buildRef(NB, MB, TB, {192'd0, 64'h1918_1110_0908_0100}, ZD);
      @(negedge clk);
      keyB = 64'h1918_1110_0908_0100; startB = 1'b1;
      @(posedge clk); #1;
      startB = 1'b0;
      doneCyc = -1; pulses = 0;
      for (int cyc = 1; cyc <= 100 && doneCyc < 0; cyc++) begin
         @(posedge clk); #1;
         if (rkValidB === 1'b1) begin
            pulses++;
            checks++;
            if (rkIdxB !== AWB'(cyc + MB - 2) || rkDataB !== refK[cyc+MB-2][15:0]) begin
               errors++;
               $display("[TB] FAIL m4_stream got idx %0d key %h want idx %0d key %h",
                        rkIdxB, rkDataB, cyc + MB - 2, refK[cyc+MB-2][15:0]);
            end
         end
         if (doneB === 1'b1) doneCyc = cyc;
      end
      checks++;
      if (doneCyc != TB - MB + 2 || pulses != TB - MB) begin
         errors++;
         $display("[TB] FAIL m4_done got cycle %0d pulses %0d want %0d %0d",
                  doneCyc, pulses, TB - MB + 2, TB - MB);
      end
      rdAddrB = AWB'(TB - 1);
      @(posedge clk); #1;
      checks++;
      if (rdDataB !== refK[TB-1][15:0]) begin
         errors++;
         $display("[TB] FAIL m4_readback got %h want %h", rdDataB, refK[TB-1][15:0]);
      end
      rdAddrB = AWB'(100);
      @(posedge clk); #1;
      checks++;
      if (rdDataB !== 16'h0) begin
         errors++;
         $display("[TB] FAIL m4_read_oob got %h want 0000", rdDataB);
      end
   endtask

   task automatic test_m2();
      int doneCyc, pulses;
      buildRef(NC, MC, TC, {208'd0, 48'h0d0c0b_050403}, ZC);
      @(negedge clk);
      keyC = 48'h0d0c0b_050403; startC = 1'b1;
      @(posedge clk); #1;
      startC = 1'b0;
      doneCyc = -1; pulses = 0;
      for (int cyc = 1; cyc <= 60 && doneCyc < 0; cyc++) begin
         @(posedge clk); #1;
         if (rkValidC === 1'b1) begin
            pulses++;
            checks++;
            if (rkIdxC !== AWC'(cyc + MC - 2) || rkDataC !== refK[cyc+MC-2][23:0]) begin
               errors++;
               $display("[TB] FAIL m2_stream got idx %0d key %h want idx %0d key %h",
                        rkIdxC, rkDataC, cyc + MC - 2, refK[cyc+MC-2][23:0]);
            end
         end
         if (doneC === 1'b1) doneCyc = cyc;
      end
      checks++;
      if (doneCyc != TC - MC + 2 || pulses != TC - MC) begin
         errors++;
         $display("[TB] FAIL m2_done got cycle %0d pulses %0d want %0d %0d",
                  doneCyc, pulses, TC - MC + 2, TC - MC);
      end
      rdAddrC = AWC'(TC - 1);
      @(posedge clk); #1;
      checks++;
      if (rdDataC !== refK[TC-1][23:0]) begin
         errors++;
         $display("[TB] FAIL m2_readback got %h want %h", rdDataC, refK[TC-1][23:0]);
      end
   endtask

   task automatic test_reset_abort();
      int  doneCyc, pulses;
      bit  sawDone;
      @(negedge clk);
      keyA = 96'h1b1a1918_13121110_0b0a0908; startA = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      checks++;
      if (busyA !== 1'b1 || keysValidA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_in_gen got busy %b kv %b want 1 0", busyA, keysValidA);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (busyA !== 1'b0 || keysValidA !== 1'b0 || doneA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_state got busy %b kv %b done %b want 0 0 0", busyA, keysValidA, doneA);
      end
      sawDone = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(posedge clk); #1;
         if (doneA !== 1'b0 || rkValidA !== 1'b0 || busyA !== 1'b0) sawDone = 1'b1;
      end
      checks++;
      if (sawDone) begin
         errors++;
         $display("[TB] FAIL abort_quiet got activity 1 want 0");
      end
      buildRef(NA, MA, TA, {160'd0, 96'h1b1a1918_13121110_0b0a0908}, ZD);
      @(negedge clk);
      startA = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      doneCyc = -1; pulses = 0;
      for (int cyc = 1; cyc <= 60 && doneCyc < 0; cyc++) begin
         @(posedge clk); #1;
         if (rkValidA === 1'b1) begin
            pulses++;
            checks++;
            if (rkIdxA !== AWA'(cyc + 1) || rkDataA !== refK[cyc+1][31:0]) begin
               errors++;
               $display("[TB] FAIL restart_stream got idx %0d key %h want idx %0d key %h",
                        rkIdxA, rkDataA, cyc + 1, refK[cyc+1][31:0]);
            end
         end
         if (doneA === 1'b1) doneCyc = cyc;
      end
      checks++;
      if (doneCyc != TA - MA + 2 || pulses != TA - MA || keysValidA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL restart_done got cycle %0d pulses %0d kv %b want %0d %0d 1",
                  doneCyc, pulses, keysValidA, TA - MA + 2, TA - MA);
      end
      rdAddrA = '0;
      @(posedge clk); #1;
      checks++;
      if (rdDataA !== refK[0][31:0]) begin
         errors++;
         $display("[TB] FAIL restart_ram0 got %h want %h", rdDataA, refK[0][31:0]);
      end
   endtask

   task automatic test_start_hold();
      int doneCyc, pulses, doneCount;
      bit busyLater;
      buildRef(NA, MA, TA, {160'd0, 96'hdeadbeef_01234567_89abcdef}, ZD);
      @(negedge clk);
      keyA = 96'hdeadbeef_01234567_89abcdef; startA = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (keysValidA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_kv_drop got %b want 0", keysValidA);
      end
      doneCyc = -1; pulses = 0; doneCount = 0; busyLater = 1'b0;
      for (int cyc = 0; cyc <= 50; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
            if (rkValidA === 1'b1) begin
               pulses++;
               checks++;
               if (rkIdxA !== AWA'(cyc + 1) || rkDataA !== refK[cyc+1][31:0]) begin
                  errors++;
                  $display("[TB] FAIL hold_stream got idx %0d key %h want idx %0d key %h",
                           rkIdxA, rkDataA, cyc + 1, refK[cyc+1][31:0]);
               end
            end
            if (doneA === 1'b1) begin
               doneCount++;
               doneCyc = cyc;
            end
            if (cyc >= 42 && busyA !== 1'b0) busyLater = 1'b1;
         end
         startA = (cyc + 1 <= 2) || (cyc + 1 == 20) || (cyc + 1 == 41);
      end
      checks++;
      if (pulses != TA - MA || doneCount != 1 || doneCyc != TA - MA + 2) begin
         errors++;
         $display("[TB] FAIL hold_single_run got pulses %0d dones %0d cycle %0d want %0d 1 %0d",
                  pulses, doneCount, doneCyc, TA - MA, TA - MA + 2);
      end
      checks++;
      if (busyLater) begin
         errors++;
         $display("[TB] FAIL hold_no_rerun got busy 1 want 0");
      end
      startA = 1'b1;
      @(posedge clk); #1;
      startA = 1'b0;
      checks++;
      if (busyA !== 1'b1 || keysValidA !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_idle_start got busy %b kv %b want 1 0", busyA, keysValidA);
      end
      doneCyc = -1;
      for (int cyc = 1; cyc <= 60 && doneCyc < 0; cyc++) begin
         @(posedge clk); #1;
         if (doneA === 1'b1) doneCyc = cyc;
      end
      checks++;
      if (doneCyc != TA - MA + 2 || keysValidA !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_second_done got cycle %0d kv %b want %0d 1", doneCyc, keysValidA, TA - MA + 2);
      end
   endtask

   // Scenario sequence
   initial begin
      checks = 0;
      errors = 0;
      $display("[TB] simon_key_expander bench starting");
      test_reset();
      test_expand();
      test_readback();
      test_m4_wrap();
      test_m2();
      test_reset_abort();
      test_start_hold();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
